// File: rtl/spec_capture_ctrl.sv
// FFT spectrum capture controller: averages 2^AVG_LOG2 magnitude frames
// and writes the averaged frame to the spectrum RAM write port.
module spec_capture_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              fft_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              busy,
    output logic              frame_err
);

    localparam int N_BINS = 1 << ADDR_W;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int FW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [FW-1:0]     F_LAST   = FW'((1 << AVG_LOG2) - 1);
    localparam logic [ADDR_W-1:0] BIN_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t            state, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] bin;
    logic [FW-1:0]     frame;
    logic [ACC_W-1:0]  acc [N_BINS];

    logic             accept;
    logic             at_end;
    logic             good_end;
    logic             bad_end;
    logic             final_frame;
    logic [ACC_W-1:0] acc_rd;
    logic [ACC_W-1:0] sum;

    assign accept      = (state == CAPTURE) && in_valid && !abort;
    assign at_end      = (bin == BIN_LAST);
    assign good_end    = accept && in_last && at_end;
    assign bad_end     = accept && (in_last != at_end);
    assign final_frame = (frame == F_LAST);
    // Frame 0 overwrites, so the stale accumulator contents never leak in.
    assign acc_rd      = (frame == '0) ? '0 : acc[bin];
    assign sum         = acc_rd + ACC_W'(in_data);

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign fft_en = (state == CAPTURE) || ((state == DONE) && mode_q);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = CAPTURE;
            CAPTURE: if (good_end && final_frame) state_d = DONE;
            DONE:    state_d = mode_q ? CAPTURE : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            bin       <= '0;
            frame     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE && start && !abort) begin
                mode_q <= mode;
                bin    <= '0;
                frame  <= '0;
            end
            if (bad_end) begin
                frame_err <= 1'b1;
                bin       <= '0;
            end else if (accept) begin
                if (final_frame) begin
                    wr_en   <= 1'b1;
                    wr_addr <= bin;
                    wr_data <= DATA_W'(sum >> AVG_LOG2);
                end
                if (good_end) begin
                    bin   <= '0;
                    frame <= final_frame ? '0 : frame + 1'b1;
                end else begin
                    bin <= bin + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !bad_end && !final_frame) acc[bin] <= sum;
    end

endmodule
